ext_clk_monitor: RTL

EXT_CLK_MONITOR -- requirements
Module: ext_clk_monitor

---
 rtl/ext_clk_monitor_pkg.sv | 26 ++
 rtl/ext_clk_monitor_edge_sync.sv | 28 ++
 rtl/ext_clk_monitor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ext_clk_monitor_pkg.sv
// Shared constants for the external reference clock monitor: FSM encodings,
// default window settings and the window acceptance test.
package ext_clk_monitor_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_QUALIFY = 3'd1;
   localparam logic [2:0] ST_LOCKED  = 3'd2;
   localparam logic [2:0] ST_FAULT   = 3'd3;

   localparam int unsigned DEF_WIN_LEN      = 1000;
   localparam int unsigned DEF_MIN_EDGES    = 95;
   localparam int unsigned DEF_MAX_EDGES    = 105;
   localparam int unsigned DEF_QUAL_WINDOWS = 4;
   localparam int unsigned DEF_FAIL_WINDOWS = 2;
   localparam int unsigned DEF_HOLDOFF_WIN  = 8;

   localparam int unsigned CNT_W = 16;

   // Inclusive range test on a completed window's edge count.
   function automatic logic edge_count_ok(input logic [CNT_W-1:0] cnt,
                                          input int unsigned lo,
                                          input int unsigned hi);
      return ({16'b0, cnt} >= lo) && ({16'b0, cnt} <= hi);
   endfunction

endpackage

// File: rtl/ext_clk_monitor_edge_sync.sv
// Two-flop synchronizer plus history flop for the raw external reference;
// emits a one-cycle pulse per synchronized rising edge.
module clk_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ext_clk_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic hist_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= ext_clk_i;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~hist_q;

endmodule

// File: rtl/ext_clk_monitor.sv
// Counts external reference edges per fixed window and switches between the
// standard and external clock through IDLE/QUALIFY/LOCKED/FAULT.
module ext_clk_monitor
   import ext_clk_monitor_pkg::*;
#(
   parameter int unsigned WIN_LEN      = DEF_WIN_LEN,
   parameter int unsigned MIN_EDGES    = DEF_MIN_EDGES,
   parameter int unsigned MAX_EDGES    = DEF_MAX_EDGES,
   parameter int unsigned QUAL_WINDOWS = DEF_QUAL_WINDOWS,
   parameter int unsigned FAIL_WINDOWS = DEF_FAIL_WINDOWS,
   parameter int unsigned HOLDOFF_WIN  = DEF_HOLDOFF_WIN
) (
   input  logic        Clk_100M,
   input  logic        SYS_RST,
   input  logic        Enable,
   input  logic        Ext_Clk_In,
   input  logic        Fault_Clr,
   output logic        UseExtClk,
   output logic        ClkFault,
   output logic [15:0] EdgeCount,
   output logic [2:0]  State
);

   localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

   logic             edge_pulse;
   logic [2:0]       state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] edge_q, edge_d;
   logic [CNT_W-1:0] ecount_q, ecount_d;
   logic [CNT_W-1:0] good_q, good_d;
   logic [CNT_W-1:0] bad_q, bad_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             use_q, use_d;
   logic             fault_q, fault_d;

   logic             eval;
   logic             win_good;
   logic             fault_set;
   logic [CNT_W-1:0] edge_sum;
   logic [CNT_W-1:0] good_inc;
   logic [CNT_W-1:0] bad_inc;
   logic [CNT_W-1:0] hold_inc;

   clk_edge_sync u_sync (
      .clk_i     (Clk_100M),
      .rst_i     (SYS_RST),
      .ext_clk_i (Ext_Clk_In),
      .edge_o    (edge_pulse)
   );

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      edge_d    = edge_q;
      ecount_d  = ecount_q;
      good_d    = good_q;
      bad_d     = bad_q;
      hold_d    = hold_q;
      fault_set = 1'b0;

      eval     = (state_q != ST_IDLE) && (win_q == WIN_LAST);
      // A pulse landing on the evaluation cycle still belongs to this window.
      edge_sum = (edge_q == '1) ? edge_q : edge_q + {{(CNT_W-1){1'b0}}, edge_pulse};
      win_good = edge_count_ok(edge_sum, MIN_EDGES, MAX_EDGES);
      good_inc = good_q + 16'd1;
      bad_inc  = bad_q + 16'd1;
      hold_inc = hold_q + 16'd1;

      if (!Enable) begin
         state_d = ST_IDLE;
         win_d   = '0;
         edge_d  = '0;
         good_d  = '0;
         bad_d   = '0;
         hold_d  = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_QUALIFY;
      end else if (eval) begin
         win_d    = '0;
         edge_d   = '0;
         ecount_d = edge_sum;
         case (state_q)
            ST_QUALIFY: begin
               if (!win_good) begin
                  good_d = '0;
               end else if (good_inc == 16'(QUAL_WINDOWS)) begin
                  good_d  = '0;
                  state_d = ST_LOCKED;
               end else begin
                  good_d = good_inc;
               end
            end
            ST_LOCKED: begin
               if (win_good) begin
                  bad_d = '0;
               end else if (bad_inc == 16'(FAIL_WINDOWS)) begin
                  bad_d     = '0;
                  state_d   = ST_FAULT;
                  fault_set = 1'b1;
               end else begin
                  bad_d = bad_inc;
               end
            end
            ST_FAULT: begin
               if (hold_inc == 16'(HOLDOFF_WIN)) begin
                  hold_d  = '0;
                  good_d  = '0;
                  state_d = ST_QUALIFY;
               end else begin
                  hold_d = hold_inc;
               end
            end
            default: ;
         endcase
      end else begin
         win_d  = win_q + 1'b1;
         edge_d = edge_sum;
      end

      use_d   = (state_d == ST_LOCKED);
      fault_d = fault_set ? 1'b1 : (Fault_Clr ? 1'b0 : fault_q);
   end

   always_ff @(posedge Clk_100M) begin
      if (SYS_RST) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         edge_q   <= '0;
         ecount_q <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         hold_q   <= '0;
         use_q    <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         edge_q   <= edge_d;
         ecount_q <= ecount_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         hold_q   <= hold_d;
         use_q    <= use_d;
         fault_q  <= fault_d;
      end
   end

   assign UseExtClk = use_q;
   assign ClkFault  = fault_q;
   assign EdgeCount = ecount_q;
   assign State     = state_q;

endmodule
